mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the memory access length in cycles (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset=0 asserts).
REQ-004 The block SHALL have ports cpu_req, cpu_we (input, 1 each): the CPU access request and write enable.
REQ-005 The block SHALL have ports cpu_addr, cpu_wdata (input, 32 each) and cpu_rdata (output, 32): the CPU address, write data and read data.
REQ-006 The block SHALL have ports cpu_ack (output, 1): one-cycle completion pulse, and cpu_stall (output, 1): CPU must hold pcen low.
REQ-007 The block SHALL have DMA-port equivalents dma_req, dma_we, dma_addr, dma_wdata, dma_rdata and dma_ack, with the same widths and meanings as the CPU port.
REQ-008 The block SHALL have ports mem_en, mem_we (output, 1 each), mem_addr, mem_wdata (output, 32 each) and mem_rdata (input, 32): the unified memory port.
REQ-009 The block SHALL have port busy (output, 1): high in any state other than IDLE.

Function
REQ-010 The block SHALL implement the FSM states IDLE, ACCESS and DONE, plus a 1-bit last_grant register (CPU/DMA) and a 4-bit wait counter.
REQ-011 In IDLE with no request, the block SHALL stay in IDLE.
REQ-012 In IDLE with exactly one request, the block SHALL grant that requester, latch its addr, we and wdata, load counter=WAIT_CYCLES-1, and go to ACCESS.
REQ-013 In IDLE with both requests, the block SHALL grant the requester that is not last_grant (round-robin).
REQ-014 last_grant SHALL update on every grant.
REQ-015 In ACCESS the block SHALL drive mem_en=1, mem_we=latched we, and mem_addr/mem_wdata from the latched values.
REQ-016 In ACCESS the counter SHALL decrement each cycle; at counter=0 the block SHALL go to DONE.
REQ-017 On the ACCESS exit edge the block SHALL capture mem_rdata into the granted port's rdata register, for reads only; on writes rdata holds its previous value.
REQ-018 The non-granted rdata register SHALL remain unchanged on every access.
REQ-019 In DONE the block SHALL pulse the granted ack for exactly one cycle, with mem_en=0, then return to IDLE.
REQ-020 Latency SHALL be: a request sampled in IDLE at edge N gives mem_en high for cycles N+1..N+WAIT_CYCLES and ack high in cycle N+WAIT_CYCLES+1.
REQ-021 Each access SHALL occupy WAIT_CYCLES+2 cycles from grant to next-arbitration opportunity.
REQ-022 Request inputs SHALL be ignored in ACCESS and DONE; requests arriving then wait for IDLE.
REQ-023 A requester clears req on the edge where it samples ack=1; a req still high in IDLE SHALL be treated as a new request.
REQ-024 Request lines SHALL be level-sensitive with no queueing; a req dropped before grant is lost without error.
REQ-025 The block SHALL drive cpu_stall = cpu_req & ~cpu_ack combinationally, including while the DMA holds the memory.
REQ-026 The block SHALL drive mem_we=0 whenever mem_en=0.
REQ-027 mem_addr and mem_wdata SHALL hold their last latched values outside ACCESS.
REQ-028 With WAIT_CYCLES=1, ACCESS SHALL last exactly one cycle.
REQ-029 A continuously requesting CPU and DMA SHALL alternate grants, with neither receiving two consecutive grants.

Reset
REQ-030 While reset=0, asynchronously: state=IDLE, last_grant=DMA (so the first tie goes to CPU), counter=0, all latched addr/wdata/we=0, cpu_rdata=dma_rdata=0, cpu_ack=dma_ack=0, mem_en=mem_we=0, busy=0.
REQ-031 Reset asserted mid-ACCESS SHALL drop mem_en immediately without waiting for a clock edge, and the aborted access SHALL produce no ack.
REQ-032 After reset release, the first arbitration SHALL occur on the first rising edge with reset=1.

Verification
REQ-033 Bench SHALL cover CPU read alone (WAIT_CYCLES=2): cpu_req=1, addr=0x40, mem_rdata=0x1234 -> mem_en high 2 cycles, cpu_ack in cycle 3, cpu_rdata=0x1234.
REQ-034 Bench SHALL cover simultaneous requests after reset: first grant CPU, second DMA, third CPU; no ack overlap.
REQ-035 Bench SHALL cover a DMA write of 0xDEADBEEF to 0x100 while cpu_req=1: mem_we=1 for 2 cycles, cpu_stall=1 throughout, cpu_rdata unchanged, CPU granted next.
REQ-036 Bench SHALL cover reset pulsed low in the 1st ACCESS cycle: mem_en=0 at once, no ack, busy=0, next grant at first edge after release.
REQ-037 Bench SHALL cover WAIT_CYCLES=1: one mem_en cycle, ack at N+2, back-to-back CPU reads at a 3-cycle period.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_arbiter                                                            |
// | Round-robin CPU/DMA arbiter onto a single fixed-latency memory port.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic       c_GRANT_CPU = 1'b0;
    localparam logic       c_GRANT_DMA = 1'b1;
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic [3:0]  r_count;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_mem_en;
    logic        r_mem_we;
    logic        r_cpu_ack;
    logic        r_dma_ack;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_dma_rdata;

    logic        w_any_req;
    logic        w_pick_dma;

    // DMA wins when alone, or on a tie when the CPU was served last.
    assign w_any_req  = cpu_req | dma_req;
    assign w_pick_dma = dma_req & (~cpu_req | (r_last_grant == c_GRANT_CPU));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= c_GRANT_CPU;
            r_last_grant <= c_GRANT_DMA;
            r_count      <= 4'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_dma_ack    <= 1'b0;
            r_cpu_rdata  <= 32'd0;
            r_dma_rdata  <= 32'd0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant      <= w_pick_dma;
                        r_last_grant <= w_pick_dma;
                        r_addr       <= w_pick_dma ? dma_addr  : cpu_addr;
                        r_wdata      <= w_pick_dma ? dma_wdata : cpu_wdata;
                        r_mem_we     <= w_pick_dma ? dma_we    : cpu_we;
                        r_mem_en     <= 1'b1;
                        r_count      <= c_WAIT_LOAD;
                        r_state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_count == 4'd0) begin
                        // Writes leave both read-data registers untouched.
                        if (!r_mem_we) begin
                            if (r_grant == c_GRANT_DMA) begin
                                r_dma_rdata <= mem_rdata;
                            end else begin
                                r_cpu_rdata <= mem_rdata;
                            end
                        end
                        if (r_grant == c_GRANT_DMA) begin
                            r_dma_ack <= 1'b1;
                        end else begin
                            r_cpu_ack <= 1'b1;
                        end
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign dma_ack   = r_dma_ack;
    assign cpu_stall = cpu_req & ~r_cpu_ack;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_arbiter                                                         |
// | Randomised and directed bench for mem_arbiter with a timeline model.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    // second instance with a one-cycle memory
    logic        c1_req = 1'b0;
    logic [31:0] c1_addr = 32'h40;
    logic        d1_req = 1'b0;
    logic [31:0] c1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        c1_ack, c1_stall, d1_ack, m1_en, m1_we, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h40) return 32'h1234;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign mem_rdata = memfn(mem_addr);
    assign m1_rdata  = memfn(m1_addr);

    mem_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr), .cpu_wdata(32'd0),
        .cpu_rdata(c1_rdata), .cpu_ack(c1_ack), .cpu_stall(c1_stall),
        .dma_req(d1_req), .dma_we(1'b0), .dma_addr(32'd0), .dma_wdata(32'd0),
        .dma_rdata(d1_rdata), .dma_ack(d1_ack),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each access is a grant edge g; memory busy for edges
    // g..g+W-1, ack after edge g+W, next arbitration at edge g+W+2.
    int          t = 0;
    int          m_free, m_g;
    bit          m_active, m_last, m_who, m_we;
    logic [31:0] m_addr, m_wdata, e_cpu_rdata, e_dma_rdata;
    bit          e_cpu_ack, e_dma_ack;

    task automatic model_reset();
        m_free = t + 1; m_g = 0; m_active = 0; m_last = 1; m_who = 0; m_we = 0;
        m_addr = 0; m_wdata = 0; e_cpu_rdata = 0; e_dma_rdata = 0;
        e_cpu_ack = 0; e_dma_ack = 0;
    endtask

    task automatic model_edge();
        bit who;
        if (m_active && t == m_g + W && !m_we) begin
            if (m_who) e_dma_rdata = memfn(m_addr);
            else       e_cpu_rdata = memfn(m_addr);
        end
        if (t >= m_free && (cpu_req || dma_req)) begin
            who      = (cpu_req && dma_req) ? !m_last : dma_req;
            m_who    = who;
            m_last   = who;
            m_g      = t;
            m_free   = t + W + 2;
            m_active = 1;
            m_we     = who ? dma_we : cpu_we;
            m_addr   = who ? dma_addr : cpu_addr;
            m_wdata  = who ? dma_wdata : cpu_wdata;
        end
    endtask

    task automatic compare();
        bit in_acc;
        in_acc    = m_active && t >= m_g && t <= m_g + W - 1;
        e_cpu_ack = m_active && t == m_g + W && !m_who;
        e_dma_ack = m_active && t == m_g + W && m_who;
        check("mem_en",    mem_en,    in_acc);
        check("mem_we",    mem_we,    in_acc && m_we);
        check("busy",      busy,      m_active && t <= m_g + W);
        check("cpu_ack",   cpu_ack,   e_cpu_ack);
        check("dma_ack",   dma_ack,   e_dma_ack);
        check("cpu_stall", cpu_stall, cpu_req && !e_cpu_ack);
        check("cpu_rdata", cpu_rdata, e_cpu_rdata);
        check("dma_rdata", dma_rdata, e_dma_rdata);
        check("mem_addr",  mem_addr,  m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
    endtask

    // mode 0: drop on ack only; 1: re-request at once; 2: random traffic
    task automatic agents(input int mode);
        bit served_c, served_d;
        served_c = m_active && !m_who && t <= m_g + W;
        served_d = m_active &&  m_who && t <= m_g + W;
        if (e_cpu_ack) cpu_req = 0;
        else if (!cpu_req) begin
            if (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1)) begin
                cpu_req = 1; cpu_we = 1'($urandom_range(1, 0));
                cpu_addr = $urandom; cpu_wdata = $urandom;
            end
        end else if (mode == 2 && !served_c && $urandom_range(9, 0) == 0) cpu_req = 0;
        if (e_dma_ack) dma_req = 0;
        else if (!dma_req) begin
            if (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1)) begin
                dma_req = 1; dma_we = 1'($urandom_range(1, 0));
                dma_addr = $urandom; dma_wdata = $urandom;
            end
        end else if (mode == 2 && !served_d && $urandom_range(9, 0) == 0) dma_req = 0;
    endtask

    task automatic step(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            t++;
            model_edge();
            @(negedge clk);
            compare();
            agents(mode);
        end
    endtask

    // Holds reset across one rising edge, checking outputs drop asynchronously.
    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_busy",   busy,   1'b0);
        @(posedge clk);
        @(negedge clk);
        check("rst_cpu_ack",   cpu_ack,   1'b0);
        check("rst_dma_ack",   dma_ack,   1'b0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_dma_rdata", dma_rdata, 32'd0);
        check("rst_mem_addr",  mem_addr,  32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        @(negedge clk);
        pulse_reset();

        // CPU read alone at 0x40
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        step(5, 0);
        check("cpu_read_0x40", cpu_rdata, 32'h1234);

        // DMA write while the CPU waits; CPU was served last so DMA wins
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44;
        dma_req = 1; dma_we = 1; dma_addr = 32'h100; dma_wdata = 32'hDEADBEEF;
        step(10, 0);
        check("cpu_rdata_after_dma", cpu_rdata, memfn(32'h44));

        // simultaneous, continuous requests after reset
        pulse_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h200;
        dma_req = 1; dma_we = 0; dma_addr = 32'h300;
        step(16, 1);
        step(10, 0);

        // reset during the first ACCESS cycle
        pulse_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
        step(1, 0);
        pulse_reset();
        step(6, 0);

        // randomised traffic
        step(400, 2);
        step(12, 0);

        // one-cycle memory: continuous CPU reads every three cycles
        @(negedge clk);
        c1_req = 1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("w1_mem_en", m1_en, (k % 3) == 0);
            check("w1_ack", c1_ack, (k % 3) == 1);
            if (k == 1) check("w1_rdata", c1_rdata, 32'h1234);
        end
        c1_req = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
